// File: rtl/anubis_qbox_sched_pkg.sv
// Shared constants for the nibble-serial Q mini-box scheduler: FSM states,
// requester ids and the Q reference table.
package anubis_qbox_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Q mini-box involution, entry n holds Q(n); listed from index 15 down to 0.
    localparam logic [15:0][3:0] Q_TABLE = {
        4'h8, 4'h1, 4'hB, 4'h7, 4'hD, 4'h4, 4'h0, 4'hF,
        4'hC, 4'h3, 4'h2, 4'hA, 4'h6, 4'h5, 4'hE, 4'h9
    };

endpackage

// File: rtl/anubis_qbox_sched_if.sv
// Handshake bundle between the two requesters, the result consumer and the
// Q mini-box scheduler.
interface anubis_qbox_sched_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             busy;
    logic             err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id, busy, err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id, busy, err
    );
endinterface

// File: rtl/anubis_q_minibox.sv
// 4-bit Q mini-box of the Anubis S-box (an involution).
module anubis_q_minibox (
    input  logic [3:0] nib,
    output logic [3:0] q
);
    always_comb begin
        q = '0;
        case (nib)
            4'h0: q = 4'h9;
            4'h1: q = 4'hE;
            4'h2: q = 4'h5;
            4'h3: q = 4'h6;
            4'h4: q = 4'hA;
            4'h5: q = 4'h2;
            4'h6: q = 4'h3;
            4'h7: q = 4'hC;
            4'h8: q = 4'hF;
            4'h9: q = 4'h0;
            4'hA: q = 4'h4;
            4'hB: q = 4'hD;
            4'hC: q = 4'h7;
            4'hD: q = 4'hB;
            4'hE: q = 4'h1;
            4'hF: q = 4'h8;
            default: q = '0;
        endcase
    end
endmodule

// File: rtl/anubis_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last
// time is granted. last_grant resets to requester 1 so requester 0 wins first.
module anubis_rr_arb2
    import anubis_qbox_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);
    logic last_grant;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (valid0 && valid1) begin
                grant0 = (last_grant == REQ_ID1);
                grant1 = (last_grant == REQ_ID0);
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_ID1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1 ? REQ_ID1 : REQ_ID0;
        end
    end
endmodule

// File: rtl/anubis_qbox_sched.sv
// Shares one Q mini-box between the round datapath and key schedule, one nibble
// per cycle. Define ANUBIS_QSCHED_CHECK_EN to add a second box as a self-check.
module anubis_qbox_sched
    import anubis_qbox_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    anubis_qbox_sched_if.slave  bus
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             id_q;
    logic [3:0]       q_out;
    logic             grant0, grant1;
    logic             accept;

    anubis_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == ST_IDLE),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    anubis_q_minibox u_q (
        .nib (sh[3:0]),
        .q   (q_out)
    );

    // Ready equals grant, so any grant in IDLE is an accepted word.
    assign accept = grant0 || grant1;

    always_comb begin
        state_nx       = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req0_ready = grant0;
                bus.req1_ready = grant1;
                if (accept) state_nx = ST_SUB;
            end
            ST_SUB:  if (cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sh    <= '0;
            cnt   <= '0;
            id_q  <= REQ_ID0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (accept) begin
                    sh   <= grant1 ? bus.req1_data : bus.req0_data;
                    id_q <= grant1 ? REQ_ID1 : REQ_ID0;
                    cnt  <= '0;
                end
                ST_SUB: begin
                    // Substituted nibble re-enters at the top; after NIB shifts it is home.
                    sh  <= {q_out, sh[WIDTH-1:4]};
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = sh;
    assign bus.out_id    = id_q;
    assign bus.busy      = (state != ST_IDLE);

`ifdef ANUBIS_QSCHED_CHECK_EN
    logic [3:0] q_chk;
    logic       err_q;

    anubis_q_minibox u_q_chk (
        .nib (q_out),
        .q   (q_chk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == ST_SUB && q_chk != sh[3:0]) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_anubis_qbox_sched.sv
// Directed plus randomized bench for anubis_qbox_sched against a word-level
// reference (table substitution per nibble, round-robin grant by rule).
module tb_anubis_qbox_sched;
    import anubis_qbox_sched_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    anubis_qbox_sched_if #(.WIDTH(WIDTH)) bus ();

    anubis_qbox_sched #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          tests = 0;
    int          failed = 0;
    logic        model_last;
    logic [31:0] d0, d1;

    function automatic logic [31:0] qsub(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < int'(NIB); i++) r[i*4 +: 4] = Q_TABLE[w[i*4 +: 4]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE: grant, substitution, optional
    // backpressure hold, output handshake.
    task automatic transact(input bit v0, input bit v1, input int hold, input bit chk_data);
        logic        exp_id;
        logic [31:0] exp_data;
        int          lat;
        exp_id = (v0 && v1) ? ~model_last : v1;
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_data  = d0;
        bus.req1_data  = d1;
        #1;
        check("grant_ready", {30'd0, bus.req1_ready, bus.req0_ready}, exp_id ? 32'd2 : 32'd1);
        exp_data = qsub(exp_id ? d1 : d0);
        step();
        model_last = exp_id;
        if (exp_id) d1 = $urandom; else d0 = $urandom;
        bus.req0_data = d0;
        bus.req1_data = d1;
        check("sub_busy_noready", {29'd0, bus.busy, bus.req1_ready, bus.req0_ready}, 32'd4);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        // Cycle T+NIB+1 is the one that begins at edge T+NIB.
        check("latency", lat, NIB);
        if (chk_data) check("out_data", bus.out_data, exp_data);
        check("out_id", {31'd0, bus.out_id}, {31'd0, exp_id});
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_ctrl", {27'd0, bus.out_valid, bus.busy, bus.out_id, bus.req1_ready, bus.req0_ready},
                  {27'd0, 1'b1, 1'b1, exp_id, 1'b0, 1'b0});
            if (chk_data) check("hold_data", bus.out_data, exp_data);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("after_out", {30'd0, bus.out_valid, bus.busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {26'd0, bus.out_valid, bus.busy, bus.err, bus.out_id, bus.req1_ready, bus.req0_ready}, 32'd0);
        check({tag, "_data"}, bus.out_data, 32'd0);
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        bus.out_ready  = 1'b0;
        model_last     = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_reset_vals("reset");

        // Directed single substitutions from the datasheet vectors.
        check("vec0_model", qsub(32'h01234567), 32'h9E56A23C);
        check("vec1_model", qsub(32'h89ABCDEF), 32'hF04D7B18);
        d0 = 32'h01234567;
        transact(1'b1, 1'b0, 0, 1'b1);
        d1 = 32'h89ABCDEF;
        transact(1'b0, 1'b1, 2, 1'b1);
        check("err_clean", {31'd0, bus.err}, 32'd0);

        // Fairness from reset with both requesters valid.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_last = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] order;
            order = 4'b1010;
            d0 = $urandom;
            d1 = $urandom;
            check("rr_order_model", {31'd0, ~model_last}, {31'd0, order[k]});
            transact(1'b1, 1'b1, 0, 1'b1);
        end

        // Backpressure, then a grant that must follow round-robin.
        transact(1'b1, 1'b1, 20, 1'b1);
        transact(1'b1, 1'b1, 0, 1'b1);

        // Reset in the middle of a substitution.
        d0 = $urandom;
        bus.req0_valid = 1'b1;
        bus.req0_data  = d0;
        step();
        bus.req0_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset_async");
        step();
        check_reset_vals("midreset_next");
        rst_n = 1'b1;
        model_last = 1'b1;
        step();
        check_reset_vals("midreset_release");
        transact(1'b1, 1'b0, 0, 1'b1);

        // Randomized traffic.
        for (int k = 0; k < 20; k++) begin
            int unsigned pat;
            pat = $urandom_range(3, 1);
            d0 = $urandom;
            d1 = $urandom;
            transact(pat[0], pat[1], int'($urandom_range(3, 0)), 1'b1);
        end
        check("err_after_random", {31'd0, bus.err}, 32'd0);

`ifdef ANUBIS_QSCHED_CHECK_EN
        d0 = 32'h01234567;
        force dut.q_out = 4'h0;
        transact(1'b1, 1'b0, 0, 1'b0);
        release dut.q_out;
        check("err_set", {31'd0, bus.err}, 32'd1);
        d0 = $urandom;
        transact(1'b1, 1'b0, 0, 1'b1);
        check("err_sticky", {31'd0, bus.err}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", {31'd0, bus.err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
